// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder: access-type/function encodings, FSM states, request/response bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_responder_pkg;

    // Access width/sign encodings (req.typ); any value not listed behaves as a full word.
    localparam logic [2:0] MT_X  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_W  = 3'd3;
    localparam logic [2:0] MT_D  = 3'd4;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;
    localparam logic [2:0] MT_WU = 3'd7;

    // Memory function (req.fcn).
    localparam logic M_XRD = 1'b0;
    localparam logic M_XWR = 1'b1;

    typedef enum logic [1:0] {
        MRS_IDLE = 2'd0,
        MRS_WAIT = 2'd1,
        MRS_RESP = 2'd2
    } mem_resp_state_e;

    // One bit per byte lane of a 32-bit word; bit i covers data[8*i +: 8].
    typedef logic [3:0] lane_mask_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fcn;
        logic [2:0]  typ;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] data;
    } mem_res_t;

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bundle between a core-side initiator and the memory responder.
// Latency: n/a (wires only).
// Backpressure: initiator holds req stable until it samples res_valid=1.
interface memory_responder_if;
    import memory_responder_pkg::*;

    logic     req_valid;
    mem_req_t req;
    logic     res_valid;
    mem_res_t res;

    modport master (output req_valid, output req, input  res_valid, input  res);
    modport slave  (input  req_valid, input  req, output res_valid, output res);

endinterface

// File: rtl/memory_responder_load_store_align.sv
// Byte-lane steering for stores and sign/zero extension for loads, plus misalignment detection.
// Latency: purely combinational.
// Backpressure: none.
module load_store_align
    import memory_responder_pkg::*;
(
    input  logic [2:0]  i_typ,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_raw_word,
    output lane_mask_t  o_lane_mask,
    output logic [31:0] o_wr_data,
    output logic        o_misaligned,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Bring the addressed byte down to lane 0; the halfword is picked by addr[1] only.
    assign w_shifted = i_raw_word >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_raw_word[31:16] : i_raw_word[15:0];

    // Store side: replicate data across lanes, pick enabled lanes, flag misalignment (kills the write).
    always_comb begin
        o_lane_mask  = 4'b1111;
        o_wr_data    = i_st_data;
        o_misaligned = 1'b0;
        case (i_typ)
            MT_B, MT_BU: begin
                o_lane_mask = 4'b0001 << i_addr_lo;
                o_wr_data   = {4{i_st_data[7:0]}};
            end
            MT_H, MT_HU: begin
                o_lane_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wr_data    = {2{i_st_data[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = |i_addr_lo;
            end
        endcase
        if (o_misaligned) begin
            o_lane_mask = 4'b0000;
        end
    end

    // Load side: extend the selected byte/halfword; a misaligned load returns zero.
    always_comb begin
        o_ld_data = i_raw_word;
        case (i_typ)
            MT_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            MT_BU:   o_ld_data = {24'd0, w_byte};
            MT_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            MT_HU:   o_ld_data = {16'd0, w_half};
            default: o_ld_data = i_raw_word;
        endcase
        if (o_misaligned) begin
            o_ld_data = 32'd0;
        end
    end

endmodule

// File: rtl/memory_responder.sv
// Single-port word RAM responder for the core request/response protocol, with byte/half/word access.
// Latency: res_valid is seen LATENCY edges after the accept edge; one access per LATENCY+1 cycles.
// Backpressure: no accept while WAIT/RESP; initiator holds the request until it samples res_valid.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    memory_responder_if.slave mem,
    output logic              misaligned
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    mem_resp_state_e r_state;
    mem_resp_state_e w_state_nxt;
    logic [3:0]      r_cnt;
    mem_req_t        r_req;
    logic            r_res_valid;
    logic [31:0]     r_res_data;
    logic            r_misaligned;
    logic [31:0]     r_ram [DEPTH];

    logic            w_accept;
    logic            w_enter_resp;
    mem_req_t        w_req;
    logic [AW-1:0]   w_idx;
    logic [31:0]     w_raw;
    lane_mask_t      w_lane_mask;
    logic [31:0]     w_wr_data;
    logic            w_mis;
    logic [31:0]     w_ld_data;
    logic            w_ram_we;
    logic            w_unused_addr;

    // With LATENCY=1 the RESP edge is the accept edge, so the live request is used; otherwise the latch.
    assign w_req         = (r_state == MRS_IDLE) ? mem.req : r_req;
    assign w_idx         = w_req.addr[2 +: AW];
    assign w_raw         = r_ram[w_idx];
    assign w_unused_addr = ^w_req.addr[31:2+AW];

    // A store during reset must not land even if the IDLE->RESP condition holds combinationally.
    assign w_ram_we = w_enter_resp && reset && (w_req.fcn == M_XWR) && !w_mis;

    load_store_align u_align (
        .i_typ        (w_req.typ),
        .i_addr_lo    (w_req.addr[1:0]),
        .i_st_data    (w_req.data),
        .i_raw_word   (w_raw),
        .o_lane_mask  (w_lane_mask),
        .o_wr_data    (w_wr_data),
        .o_misaligned (w_mis),
        .o_ld_data    (w_ld_data)
    );

    // Next-state: accept only in IDLE, count down in WAIT, RESP lasts exactly one cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            MRS_IDLE: begin
                if (mem.req_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt  = MRS_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = MRS_WAIT;
                    end
                end
            end
            MRS_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = MRS_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            MRS_RESP: begin
                w_state_nxt = MRS_IDLE;
            end
            default: begin
                w_state_nxt = MRS_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MRS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latch and latency counter; req_valid dropping mid-WAIT does not disturb the latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 4'd0;
            r_req <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
            r_req <= mem.req;
        end else if (r_state == MRS_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Registered response: valid/data/misaligned for one cycle, data forced to zero otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_valid  <= 1'b0;
            r_res_data   <= 32'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_res_valid  <= w_enter_resp;
            r_res_data   <= w_enter_resp ? w_ld_data : 32'd0;
            r_misaligned <= w_enter_resp & w_mis;
        end
    end

    // Byte-lane RAM write on the edge entering RESP; read data above is the pre-write word.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lane_mask[i]) begin
                    r_ram[w_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    assign mem.res_valid = r_res_valid;
    assign mem.res       = '{data: r_res_data};
    assign misaligned    = r_misaligned;

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and randomized accesses
// compared against a byte-level behavioural memory model; runs a LATENCY=1 and a LATENCY=4 instance.
module tb_memory_responder;
    import memory_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n;
    logic rst4_n;
    logic mis1;
    logic mis4;

    memory_responder_if if1 ();
    memory_responder_if if4 ();

    memory_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk        (clk),
        .reset      (rst1_n),
        .mem        (if1),
        .misaligned (mis1)
    );

    memory_responder #(.DEPTH(1024), .LATENCY(4)) u_l4 (
        .clk        (clk),
        .reset      (rst4_n),
        .mem        (if4),
        .misaligned (mis4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        fcn;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [21];

    // Behavioural memory: one array per instance, index 0 -> LATENCY=1, index 1 -> LATENCY=4.
    logic [31:0] mdl [2][1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data);
        if (sel == 1) begin
            if1.req_valid = v;
            if1.req.fcn   = fcn;
            if1.req.typ   = typ;
            if1.req.addr  = addr;
            if1.req.data  = data;
        end else begin
            if4.req_valid = v;
            if4.req.fcn   = fcn;
            if4.req.typ   = typ;
            if4.req.addr  = addr;
            if4.req.data  = data;
        end
    endtask

    task automatic peek(input int sel, output logic v, output logic [31:0] d, output logic m);
        if (sel == 1) begin
            v = if1.res_valid;
            d = if1.res.data;
            m = mis1;
        end else begin
            v = if4.res_valid;
            d = if4.res.data;
            m = mis4;
        end
    endtask

    // One complete access from an idle responder; sel is also the instance's LATENCY.
    task automatic access(input int sel, input string name, input logic fcn, input logic [2:0] typ,
                          input logic [31:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic mis);
        int          lat;
        logic        got;
        logic        v;
        logic [31:0] d;
        logic        m;
        drive(sel, 1'b1, fcn, typ, addr, data);
        lat   = 0;
        got   = 1'b0;
        rdata = 32'd0;
        mis   = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            peek(sel, v, d, m);
            if (v === 1'b1) begin
                got   = 1'b1;
                rdata = d;
                mis   = m;
            end
        end
        drive(sel, 1'b0, fcn, typ, addr, data);
        check({name, "_latency"}, 32'(lat), 32'(sel));
        @(posedge clk);
        @(negedge clk);
        peek(sel, v, d, m);
        check({name, "_idle_valid"}, {31'd0, v}, 32'd0);
        check({name, "_idle_data"}, d, 32'd0);
    endtask

    function automatic int size_of(input logic [2:0] typ);
        if (typ == MT_B || typ == MT_BU) return 1;
        if (typ == MT_H || typ == MT_HU) return 2;
        return 4;
    endfunction

    function automatic logic model_mis(input logic [2:0] typ, input logic [31:0] addr);
        return (addr % size_of(typ)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] typ,
                                               input logic [31:0] addr);
        int     sz;
        int     off;
        longint v;
        if (model_mis(typ, addr)) return 32'd0;
        sz  = size_of(typ);
        off = int'(addr % 4);
        v   = longint'(word) >> (8 * off);
        v   = v % (64'd1 << (8 * sz));
        if ((typ == MT_B || typ == MT_H) && v >= (64'd1 << (8 * sz - 1)))
            v = v - (64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] typ,
                                                input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] w;
        int          off;
        w = word;
        if (model_mis(typ, addr)) return w;
        off = int'(addr % 4);
        for (int j = 0; j < size_of(typ); j++) begin
            w[8*(off+j) +: 8] = data[8*j +: 8];
        end
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        ms;
        logic        v;
        logic [31:0] d;
        logic        m;
        int          pulses[$];

        vecs[0]  = '{M_XWR, MT_W,  32'h100,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{M_XRD, MT_W,  32'h100,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{M_XRD, MT_B,  32'h103,  32'h0,        1'b1, 32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{M_XRD, MT_BU, 32'h103,  32'h0,        1'b1, 32'h000000DE, 1'b0};
        vecs[4]  = '{M_XRD, MT_H,  32'h102,  32'h0,        1'b1, 32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{M_XRD, MT_HU, 32'h100,  32'h0,        1'b1, 32'h0000BEEF, 1'b0};
        vecs[6]  = '{M_XWR, MT_B,  32'h101,  32'hAABBCC55, 1'b0, 32'h0,        1'b0};
        vecs[7]  = '{M_XRD, MT_W,  32'h100,  32'h0,        1'b1, 32'hDEAD55EF, 1'b0};
        vecs[8]  = '{M_XWR, MT_H,  32'h101,  32'h00001234, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{M_XRD, MT_W,  32'h102,  32'h0,        1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{M_XRD, MT_W,  32'h100,  32'h0,        1'b1, 32'hDEAD55EF, 1'b0};
        vecs[11] = '{M_XRD, MT_W,  32'h1100, 32'h0,        1'b1, 32'hDEAD55EF, 1'b0};
        vecs[12] = '{M_XRD, MT_H,  32'h103,  32'h0,        1'b1, 32'h00000000, 1'b1};
        vecs[13] = '{M_XRD, MT_X,  32'h100,  32'h0,        1'b1, 32'hDEAD55EF, 1'b0};
        vecs[14] = '{M_XWR, MT_B,  32'h102,  32'h00000080, 1'b0, 32'h0,        1'b0};
        vecs[15] = '{M_XRD, MT_B,  32'h102,  32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        vecs[16] = '{M_XWR, MT_W,  32'h102,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b1};
        vecs[17] = '{M_XRD, MT_W,  32'h100,  32'h0,        1'b1, 32'hDE8055EF, 1'b0};
        vecs[18] = '{M_XRD, MT_HU, 32'h102,  32'h0,        1'b1, 32'h0000DE80, 1'b0};
        vecs[19] = '{M_XWR, MT_H,  32'h102,  32'hCAFE1234, 1'b0, 32'h0,        1'b0};
        vecs[20] = '{M_XRD, MT_WU, 32'h100,  32'h0,        1'b1, 32'h123455EF, 1'b0};

        // Reset held for 3 cycles with a request pending: no response, outputs at zero.
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        drive(1, 1'b1, M_XRD, MT_W, 32'h0, 32'h0);
        drive(4, 1'b0, M_XRD, MT_W, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            peek(1, v, d, m);
            check($sformatf("rst_valid_c%0d", c), {31'd0, v}, 32'd0);
            check($sformatf("rst_data_c%0d", c), d, 32'd0);
            check($sformatf("rst_mis_c%0d", c), {31'd0, m}, 32'd0);
        end
        rst1_n = 1'b1;
        rst4_n = 1'b1;
        access(1, "rst_first", M_XRD, MT_W, 32'h0, 32'h0, rd, ms);

        // Directed vectors on the LATENCY=1 instance.
        for (int i = 0; i < 21; i++) begin
            access(1, $sformatf("vec%0d", i), vecs[i].fcn, vecs[i].typ, vecs[i].addr,
                   vecs[i].data, rd, ms);
            check($sformatf("vec%0d_mis", i), {31'd0, ms}, {31'd0, vecs[i].exp_mis});
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
        end

        // LATENCY=4, request held continuously: one pulse every 5 cycles.
        drive(4, 1'b1, M_XRD, MT_W, 32'h100, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            peek(4, v, d, m);
            if (v === 1'b1) pulses.push_back(k);
        end
        drive(4, 1'b0, M_XRD, MT_W, 32'h100, 32'h0);
        check("b2b_count", 32'(pulses.size()), 32'd4);
        for (int j = 0; j < pulses.size(); j++) begin
            check($sformatf("b2b_pulse%0d", j), 32'(pulses[j]), 32'(4 + 5 * j));
        end

        // LATENCY=4: store aborted by reset during WAIT must not be performed.
        access(4, "pre200", M_XWR, MT_W, 32'h200, 32'h0, rd, ms);
        drive(4, 1'b1, M_XWR, MT_W, 32'h200, 32'h12345678);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            peek(4, v, d, m);
            check($sformatf("abort_wait_c%0d", c), {31'd0, v}, 32'd0);
        end
        rst4_n = 1'b0;
        drive(4, 1'b0, M_XWR, MT_W, 32'h200, 32'h12345678);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            peek(4, v, d, m);
            check($sformatf("abort_rst_c%0d", c), {31'd0, v}, 32'd0);
        end
        rst4_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            peek(4, v, d, m);
            check($sformatf("abort_after_c%0d", c), {31'd0, v}, 32'd0);
        end
        access(4, "abort_rd", M_XRD, MT_W, 32'h200, 32'h0, rd, ms);
        check("abort_rd_data", rd, 32'h0);
        check("abort_rd_mis", {31'd0, ms}, 32'd0);

        // Randomized accesses on both instances against the behavioural model.
        foreach (vecs[i]) begin end
        for (int s = 0; s < 2; s++) begin
            int sel;
            sel = (s == 0) ? 1 : 4;
            for (int k = 0; k < 16; k++) begin
                logic [31:0] val;
                logic [31:0] a;
                val = $urandom;
                a   = 32'h300 + 32'(4 * k);
                access(sel, $sformatf("pre_s%0d_k%0d", sel, k), M_XWR, MT_W, a, val, rd, ms);
                mdl[s][(a >> 2) % 1024] = val;
            end
            for (int n = 0; n < 120; n++) begin
                logic [31:0] a;
                logic [31:0] wd;
                logic [2:0]  typ;
                logic        fcn;
                int          idx;
                string       nm;
                a   = (32'($urandom_range(0, 20'hFFFFF)) << 12)
                      | (32'h300 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)));
                wd  = $urandom;
                typ = 3'($urandom_range(0, 7));
                fcn = 1'($urandom_range(0, 1));
                idx = int'((a >> 2) % 1024);
                nm  = $sformatf("rnd_s%0d_n%0d", sel, n);
                access(sel, nm, fcn, typ, a, wd, rd, ms);
                check({nm, "_mis"}, {31'd0, ms}, {31'd0, model_mis(typ, a)});
                if (fcn == M_XRD) begin
                    check({nm, "_data"}, rd, model_load(mdl[s][idx], typ, a));
                end else begin
                    mdl[s][idx] = model_store(mdl[s][idx], typ, a, wd);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
